// File: rtl/axi_interconnect_crossbar_arbit_ctrl_pkg.sv
// Shared types and helpers for the per-slave write-path grant controller.
// State encoding is fixed: IDLE=0, ADDR=1, DATA=2, RESP=3.
package axi_interconnect_crossbar_arbit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  localparam int unsigned NUM_DEFAULT = 4;

  // Bits needed to hold 'value' (minimum 1), used for master-index widths.
  function automatic int unsigned log2_w(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
// Combinational round-robin pick: first requesting master after last_user,
// wrapping at NUM. last_user must be all-ones when the last served was NUM-1.
module axi_interconnect_crossbar_arbit_polling
  import axi_interconnect_crossbar_arbit_ctrl_pkg::*;
#(
  parameter int unsigned NUM   = NUM_DEFAULT,
  parameter int unsigned WIDTH = log2_w(NUM - 1)
) (
  input  logic [NUM-1:0]   user_req,
  input  logic [WIDTH-1:0] last_user,
  output logic [WIDTH-1:0] current_user
);

  localparam int N = int'(NUM);

  logic [WIDTH-1:0] base;
  int               best_dist;

  // Search base wraps in WIDTH bits, so an all-ones last_user starts at 0.
  always_comb begin
    base         = last_user + WIDTH'(1);
    current_user = '0;
    best_dist    = N;
    for (int i = 0; i < N; i++) begin
      if (user_req[i] &&
          (((i >= int'(base)) ? (i - int'(base)) : (i - int'(base) + N)) < best_dist)) begin
        best_dist    = (i >= int'(base)) ? (i - int'(base)) : (i - int'(base) + N);
        current_user = WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/axi_interconnect_crossbar_arbit_ctrl.sv
// Per-slave write-path grant controller: holds a round-robin grant across AW, W
// and (with AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN defined) B, emitting routing enables.
module axi_interconnect_crossbar_arbit_ctrl
  import axi_interconnect_crossbar_arbit_ctrl_pkg::*;
#(
  parameter int unsigned NUM   = NUM_DEFAULT,
  parameter int unsigned WIDTH = log2_w(NUM - 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM-1:0]   user_req,
  input  logic             aw_hs,
  input  logic             w_last_hs,
  input  logic             b_hs,
  output logic             grant_valid,
  output logic [NUM-1:0]   grant_onehot,
  output logic [WIDTH-1:0] grant_id,
  output logic             aw_en,
  output logic             w_en,
  output logic             b_en
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(NUM - 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic             take;
  logic             rel;
  logic [WIDTH-1:0] last_user;
  logic [WIDTH-1:0] last_user_nxt;
  logic [WIDTH-1:0] arb_last;
  logic [WIDTH-1:0] current_user;
  logic             grant_valid_nxt;
  logic [WIDTH-1:0] grant_id_nxt;
  logic [NUM-1:0]   grant_onehot_nxt;
  logic             aw_en_nxt;
  logic             w_en_nxt;

  // Top index is presented as all-ones so the arbiter's +1 lands on 0.
  assign arb_last = (last_user == LAST_IDX) ? '1 : last_user;

  axi_interconnect_crossbar_arbit_polling #(
    .NUM   (NUM),
    .WIDTH (WIDTH)
  ) u_polling (
    .user_req     (user_req),
    .last_user    (arb_last),
    .current_user (current_user)
  );

`ifdef AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN
  logic b_en_nxt;
`else
  logic unused_b_hs;
  assign unused_b_hs = b_hs;
  assign b_en        = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_user    <= LAST_IDX;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
      aw_en        <= 1'b0;
      w_en         <= 1'b0;
`ifdef AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN
      b_en         <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      last_user    <= last_user_nxt;
      grant_valid  <= grant_valid_nxt;
      grant_id     <= grant_id_nxt;
      grant_onehot <= grant_onehot_nxt;
      aw_en        <= aw_en_nxt;
      w_en         <= w_en_nxt;
`ifdef AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN
      b_en         <= b_en_nxt;
`endif
    end
  end

  // Transaction sequencing; strobes outside their own state are ignored.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    rel       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|user_req) begin
          take      = 1'b1;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_last_hs) begin
`ifdef AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN
          state_nxt = ST_RESP;
`else
          rel       = 1'b1;
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN
      ST_RESP: begin
        if (b_hs) begin
          rel       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant capture/release and per-channel enables for the coming cycle.
  always_comb begin
    grant_valid_nxt  = grant_valid;
    grant_id_nxt     = grant_id;
    grant_onehot_nxt = grant_onehot;
    last_user_nxt    = last_user;
    if (take) begin
      grant_valid_nxt  = 1'b1;
      grant_id_nxt     = current_user;
      grant_onehot_nxt = NUM'(1) << current_user;
    end
    if (rel) begin
      grant_valid_nxt  = 1'b0;
      grant_id_nxt     = '0;
      grant_onehot_nxt = '0;
      last_user_nxt    = grant_id;
    end
    aw_en_nxt = (state_nxt == ST_ADDR);
    w_en_nxt  = (state_nxt == ST_DATA);
`ifdef AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN
    b_en_nxt  = (state_nxt == ST_RESP);
`endif
  end

endmodule

// File: tb/tb_axi_interconnect_crossbar_arbit_ctrl.sv
// Bench for axi_interconnect_crossbar_arbit_ctrl: NUM=4 and NUM=3 instances
// driven together, checked against a round-robin transaction model.
module tb_axi_interconnect_crossbar_arbit_ctrl;

`ifdef AXI_INTERCONNECT_ARBIT_BRESP_HOLD_EN
  localparam bit BHOLD = 1'b1;
`else
  localparam bit BHOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] user_req;
  logic       aw_hs;
  logic       w_last_hs;
  logic       b_hs;

  logic       gv4, aw4, w4, b4;
  logic [3:0] oh4;
  logic [1:0] id4;
  logic       gv3, aw3, w3, b3;
  logic [2:0] oh3;
  logic [1:0] id3;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 address, 2 data, 3 response
  int m_ph[2];
  int m_id[2];
  int m_last[2];
  int m_n[2] = '{4, 3};

  always #5 clk = ~clk;

  axi_interconnect_crossbar_arbit_ctrl #(.NUM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .user_req(user_req), .aw_hs(aw_hs),
    .w_last_hs(w_last_hs), .b_hs(b_hs), .grant_valid(gv4), .grant_onehot(oh4),
    .grant_id(id4), .aw_en(aw4), .w_en(w4), .b_en(b4)
  );

  axi_interconnect_crossbar_arbit_ctrl #(.NUM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .user_req(user_req[2:0]), .aw_hs(aw_hs),
    .w_last_hs(w_last_hs), .b_hs(b_hs), .grant_valid(gv3), .grant_onehot(oh3),
    .grant_id(id3), .aw_en(aw3), .w_en(w3), .b_en(b3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input int req, input int n);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (last + k) % n;
      if (((req >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r, input int req, input bit aw, input bit wl, input bit b);
    for (int i = 0; i < 2; i++) begin
      int n, rq, p;
      n  = m_n[i];
      rq = req & ((1 << n) - 1);
      if (!r) begin
        m_ph[i] = 0; m_id[i] = 0; m_last[i] = n - 1;
      end else if (m_ph[i] == 0) begin
        p = rr_pick(m_last[i], rq, n);
        if (p >= 0) begin m_id[i] = p; m_ph[i] = 1; end
      end else if (m_ph[i] == 1) begin
        if (aw) m_ph[i] = 2;
      end else if (m_ph[i] == 2) begin
        if (wl) begin
          if (BHOLD) m_ph[i] = 3;
          else begin m_last[i] = m_id[i]; m_ph[i] = 0; end
        end
      end else begin
        if (b) begin m_last[i] = m_id[i]; m_ph[i] = 0; end
      end
    end
  endtask

  task automatic compare_all();
    int v, id, oh;
    v  = (m_ph[0] != 0) ? 1 : 0;
    id = v ? m_id[0] : 0;
    oh = v ? (1 << m_id[0]) : 0;
    check("n4_valid",  32'(gv4), 32'(v));
    check("n4_id",     32'(id4), 32'(id));
    check("n4_onehot", 32'(oh4), 32'(oh));
    check("n4_aw_en",  32'(aw4), 32'(m_ph[0] == 1));
    check("n4_w_en",   32'(w4),  32'(m_ph[0] == 2));
    check("n4_b_en",   32'(b4),  32'(m_ph[0] == 3));
    v  = (m_ph[1] != 0) ? 1 : 0;
    id = v ? m_id[1] : 0;
    oh = v ? (1 << m_id[1]) : 0;
    check("n3_valid",  32'(gv3), 32'(v));
    check("n3_id",     32'(id3), 32'(id));
    check("n3_onehot", 32'(oh3), 32'(oh));
    check("n3_aw_en",  32'(aw3), 32'(m_ph[1] == 1));
    check("n3_w_en",   32'(w3),  32'(m_ph[1] == 2));
    check("n3_b_en",   32'(b3),  32'(m_ph[1] == 3));
  endtask

  // Drive one cycle of inputs at the falling edge, check after the next.
  task automatic cycle(input bit r, input logic [3:0] req, input bit aw, input bit wl, input bit b);
    rst_n     = r;
    user_req  = req;
    aw_hs     = aw;
    w_last_hs = wl;
    b_hs      = b;
    model_step(r, int'(req), aw, wl, b);
    @(negedge clk);
    compare_all();
  endtask

  task automatic finish_txn(input logic [3:0] req);
    cycle(1'b1, req, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, req, 1'b0, 1'b1, 1'b0);
    if (BHOLD) cycle(1'b1, req, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; user_req = '0; aw_hs = 1'b0; w_last_hs = 1'b0; b_hs = 1'b0;
    @(negedge clk);
    cycle(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(gv4), 32'd0);

    // First grant goes to lowest requester
    cycle(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    check("first_id", 32'(id4), 32'd1);
    check("first_onehot", 32'(oh4), 32'b0010);
    check("first_aw_en", 32'(aw4), 32'd1);

    // Stray strobes in ADDR and DATA
    cycle(1'b1, 4'b1010, 1'b0, 1'b1, 1'b1);
    check("addr_hold", 32'(aw4), 32'd1);
    cycle(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
    check("data_w_en", 32'(w4), 32'd1);
    cycle(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1);
    check("data_hold", 32'(w4), 32'd1);
    cycle(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
    if (BHOLD) begin
      check("resp_b_en", 32'(b4), 32'd1);
      check("resp_valid", 32'(gv4), 32'd1);
      cycle(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1);
      check("resp_release", 32'(gv4), 32'd0);
    end else begin
      check("wlast_release", 32'(gv4), 32'd0);
      check("b_en_tied", 32'(b4), 32'd0);
      cycle(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
      check("b_hs_ignored", 32'(gv4), 32'd0);
    end

    // Round robin moves past the last served
    cycle(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
    check("rr_next_id", 32'(id4), 32'd3);
    finish_txn(4'b1010);
    cycle(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
    check("n3_top_id", 32'(id3), 32'd2);
    finish_txn(4'b0100);

    // NUM=3 wrap from index 2 back to 0
    cycle(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    check("n3_wrap_id", 32'(id3), 32'd0);
    check("n3_wrap_onehot", 32'(oh3), 32'b001);
    finish_txn(4'b0111);

    // Reset mid-DATA
    cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
    check("pre_rst_w_en", 32'(w4), 32'd1);
    cycle(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
    check("mid_rst_valid", 32'(gv4), 32'd0);
    check("mid_rst_w_en", 32'(w4), 32'd0);
    check("mid_rst_onehot", 32'(oh4), 32'd0);
    cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    check("post_rst_id", 32'(id4), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] rq;
      rq = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom());
      cycle(($urandom_range(0, 99) != 0), rq,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
